// File: rtl/demux_route.sv
// demux_route: 1-to-NUM_LANES routing demultiplexer.
// One input word per accepted transfer is steered to the lane named by
// in_sel. Each lane keeps a single-entry holding register with valid/ack.
// Out-of-range selects are accepted and dropped, and flagged sticky.
module demux_route #(
  parameter int NUM_LANES = 32,
  parameter int SEL_W     = 5,
  parameter int DATA_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic [NUM_LANES-1:0]        out_valid,
  input  logic [NUM_LANES-1:0]        out_ack,
  output logic [15:0]                 xfer_count,
  output logic                        err_sel
);

  logic [NUM_LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_LANES-1:0]        out_valid_q, out_valid_d;
  logic [15:0]                 xfer_count_q, xfer_count_d;
  logic                        err_sel_q, err_sel_d;

  logic [NUM_LANES-1:0] lane_hit;    // one-hot decode of in_sel
  logic [NUM_LANES-1:0] lane_open;   // lane can take a word this cycle
  logic                 sel_in_range;
  logic                 accept;

  // Zero-extend before comparing so a full 2^SEL_W lane count still works.
  assign sel_in_range = (32'(in_sel) < NUM_LANES);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_hit[gi]  = (in_sel == SEL_W'(gi));
      // A lane being drained this cycle may be refilled in the same cycle.
      assign lane_open[gi] = !out_valid_q[gi] || out_ack[gi];

      // Lane next state: load beats drain, drain beats hold; data kept on drain.
      always_comb begin
        out_valid_d[gi]                   = out_valid_q[gi];
        out_data_d[gi*DATA_W +: DATA_W]   = out_data_q[gi*DATA_W +: DATA_W];
        if (accept && lane_hit[gi]) begin
          out_valid_d[gi]                 = 1'b1;
          out_data_d[gi*DATA_W +: DATA_W] = in_data;
        end else if (out_valid_q[gi] && out_ack[gi]) begin
          out_valid_d[gi]                 = 1'b0;
        end
      end
    end
  endgenerate

  // Ready is a function of the selected lane only, never of in_valid.
  assign in_ready = sel_in_range ? |(lane_hit & lane_open) : 1'b1;
  assign accept   = in_valid && in_ready;

  // Counter and sticky error next state.
  always_comb begin
    xfer_count_d = xfer_count_q;
    err_sel_d    = err_sel_q;
    if (accept && sel_in_range) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
    if (accept && !sel_in_range) begin
      err_sel_d = 1'b1;
    end
  end

  // State registers; reset clears everything without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= '0;
      xfer_count_q <= '0;
      err_sel_q    <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      xfer_count_q <= xfer_count_d;
      err_sel_q    <= err_sel_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign xfer_count = xfer_count_q;
  assign err_sel    = err_sel_q;

endmodule

// File: doc/demux_route.md
Name: demux_route

Overview:
- 1-to-NUM_LANES routing demultiplexer.
- Takes one DATA_W-bit word per accepted transfer, tagged with a lane select, and delivers it to the selected output lane.
- Each lane has a one-entry holding register with valid/ack handshake.
- Sits on the fan-out side of the 32-input, 2-bit selection datapath. It distributes one source stream to 32 consumers, where the mux collects 32 sources into one.

Parameters:
- NUM_LANES, 32, number of output lanes (2..2^SEL_W).
- SEL_W, 5, width of lane select.
- DATA_W, 2, width of each data word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  source presents a word.
- in_sel  input  SEL_W  destination lane index.
- in_data  input  DATA_W  word to route.
- in_ready  output  1  block accepts the word this cycle (combinational).
- out_data  output  NUM_LANES*DATA_W  lane i data at bits [i*DATA_W +: DATA_W].
- out_valid  output  NUM_LANES  lane i holds an undelivered word.
- out_ack  input  NUM_LANES  lane i consumer takes its word this cycle.
- xfer_count  output  16  count of words delivered into lanes.
- err_sel  output  1  sticky: a word with in_sel >= NUM_LANES was accepted.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, xfer_count=0, err_sel=0.
- Reset mid-operation discards all held words immediately, without waiting for a clock edge.
- Accept condition: in_valid && in_ready at the rising edge.
- in_ready when in_sel < NUM_LANES: 1 iff !out_valid[in_sel] || out_ack[in_sel]. This allows same-cycle replace on a lane being drained.
- in_ready when in_sel >= NUM_LANES: 1. The word is sunk and dropped, and err_sel is set to 1.
- err_sel clears only on reset.
- in_ready depends only on in_sel, out_valid and out_ack. It must not depend on in_valid.
- Lane i next state, priority order:
  - Accept with in_sel==i: out_data lane i <= in_data; out_valid[i] <= 1. This holds whether or not out_ack[i] is asserted.
  - Else out_valid[i] && out_ack[i]: out_valid[i] <= 0. out_data lane i retains its last value; it is not cleared.
  - Else hold.
- out_ack[i] while out_valid[i]==0 has no effect.
- Any number of lanes may be acked in the same cycle. At most one lane is loaded per cycle.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N. Minimum residency is one cycle.
- Per-lane ordering: a lane never holds more than one word, and a new word is accepted into a lane only when that lane is empty or draining.
- Other lanes are unaffected by a stall on one lane. Because in_ready is computed per select, there is no cross-lane blocking beyond the single input port.
- xfer_count increments by 1 per accepted in-range word. It wraps from 0xFFFF to 0x0000. Dropped (out-of-range) words do not count.
- Source contract: in_sel/in_data must remain stable while in_valid && !in_ready. The block does not check this.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst mid-cycle with lanes 3 and 7 valid.
  - Required: out_valid=0, out_data=0, xfer_count=0, err_sel=0 immediately, before the next edge.
- Basic route:
  - Stimulus: in_valid=1, in_sel=5, in_data=2'b10 for one cycle.
  - Required: next cycle out_valid=32'h0000_0020, out_data[11:10]=2'b10, xfer_count=1, in_ready for sel 5 now 0.
- Backpressure and same-cycle replace:
  - Stimulus: lane 5 holds 2'b10. Present sel=5, data=2'b01 with out_ack[5]=0.
  - Required: in_ready=0, lane unchanged.
  - Then: raise out_ack[5]=1 with the word still presented.
  - Required: in_ready=1; next cycle out_valid[5]=1, out_data[11:10]=2'b01, xfer_count=2.
- Drain and no-op ack:
  - Stimulus: ack lane 5 with no new word.
  - Required: out_valid[5]=0, out_data[11:10] stays 2'b01.
  - Then: ack lane 9 while it is empty.
  - Required: no change anywhere.
- All lanes sweep:
  - Stimulus: sel 0..31 back-to-back with data=sel[1:0], no acks.
  - Required: out_valid=32'hFFFF_FFFF, each lane holds sel[1:0], xfer_count=32.
  - Then: a further word to sel 0.
  - Required: in_ready=0.
- Out-of-range and wrap:
  - Stimulus: build with NUM_LANES=20; send sel=25.
  - Required: in_ready=1, err_sel=1, no out_valid change, xfer_count unchanged.
  - Stimulus: preload count to 16'hFFFF via 65535 transfers, then one more.
  - Required: xfer_count=0.
